// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder for the Memory Access load/store port
// Aligns byte lanes, writes with byte enables, returns sign/zero-extended loads after wait states.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_is_store,
  input  logic        req_is_load,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  width_q, width_d;
  logic        unsigned_q, unsigned_d;
  logic        load_q, load_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             malformed, misaligned, out_of_range, req_err;
  logic             accept, wr_en;
  logic [IDX_W-1:0] mem_idx;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_lanes;
  logic [31:0]      load_data;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_idx   = req_addr[IDX_W+1:2];

  always_comb begin
    malformed    = (req_is_store == req_is_load) || (req_width == 2'd3);
    misaligned   = ((req_width == 2'd1) && req_addr[0]) ||
                   ((req_width == 2'd2) && (req_addr[1:0] != 2'b00));
    out_of_range = ({2'b00, req_addr[31:2]} >= DEPTH_L);
    req_err      = malformed || misaligned || out_of_range;
  end

  // rstN gating keeps a request presented during reset from touching memory.
  assign wr_en = accept && rstN && req_is_store && !req_err;

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = req_wdata;
    case (req_width)
      2'd0: begin
        byte_en     = 4'b0001 << req_addr[1:0];
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        byte_en     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        byte_en     = 4'b1111;
        wdata_lanes = req_wdata;
      end
      default: begin
        byte_en     = 4'b0000;
        wdata_lanes = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem_q[mem_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    logic [31:0] shifted;
    shifted   = word_q >> {off_q, 3'b000};
    load_data = 32'h0;
    case (width_q)
      2'd0:    load_data = unsigned_q ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = unsigned_q ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      2'd2:    load_data = word_q;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    off_d      = off_q;
    width_d    = width_q;
    unsigned_d = unsigned_q;
    load_d     = load_q;
    err_d      = err_q;
    rsp_valid  = 1'b0;
    rsp_rdata  = 32'h0;
    rsp_error  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          word_d     = mem_q[mem_idx];
          off_d      = req_addr[1:0];
          width_d    = req_width;
          unsigned_d = req_unsigned;
          load_d     = req_is_load && !req_err;
          err_d      = req_err;
          if (WAIT_L != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_L;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_error = err_q;
        rsp_rdata = load_q ? load_data : 32'h0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      word_q     <= 32'h0;
      off_q      <= 2'b00;
      width_q    <= 2'b00;
      unsigned_q <= 1'b0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      off_q      <= off_d;
      width_q    <= width_d;
      unsigned_q <= unsigned_d;
      load_q     <= load_d;
      err_q      <= err_d;
    end
  end

endmodule
